block_deinterleaver: RTL
========================

BLOCK_DEINTERLEAVER -- requirements
Module: block_deinterleaver

Interface
REQ-001 SHALL have parameter ROWS, default 5, meaning block matrix row count.
REQ-002 SHALL have parameter COLS, default 8, meaning block matrix column count; block size BS = ROWS*COLS (default 40).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse marking the cycle that carries interleaved bit j=0.
REQ-006 SHALL have port xin, input, 1, interleaved serial data, one bit per clock.
REQ-007 SHALL have port xout, output, 1, de-interleaved serial data.
REQ-008 SHALL have port xout_valid, output, 1, qualifies xout.
REQ-009 SHALL have port busy, output, 1, high while a block is being filled or drained.
REQ-010 SHALL have port done, output, 1, one-cycle pulse coincident with the last xout bit of a block.

Function
REQ-011 SHALL implement states IDLE, FILL, DRAIN.
REQ-012 IDLE: start=1 captures xin as j=0, sets write count to 1, moves to FILL.
REQ-013 FILL: captures xin every cycle as the next j; after j=BS-1 is captured, moves to DRAIN next cycle.
REQ-014 Write mapping: bit j stored at storage index (j mod ROWS)*COLS + (j / ROWS), the inverse of the column-read interleaver.
REQ-015 DRAIN: emits storage index 0..BS-1 in order, one per cycle, xout_valid=1; the first output bit appears the cycle after j=BS-1 is sampled.
REQ-016 done SHALL pulse with index BS-1; the next cycle returns to IDLE with xout_valid=0.
REQ-017 Latency from start to first valid xout SHALL be exactly BS cycles; block throughput is 2*BS cycles.
REQ-018 start asserted during FILL SHALL restart the block: that cycle's xin becomes j=0, and earlier partial data is discarded.
REQ-019 start asserted during DRAIN SHALL be ignored; the drain completes unchanged.
REQ-020 start asserted in the same cycle as done SHALL be ignored; the block must be re-started from IDLE.
REQ-021 xout SHALL be 0 whenever xout_valid=0.
REQ-022 Counters SHALL be sized $clog2(BS) bits minimum and SHALL never wrap past BS-1.
REQ-023 busy = (state != IDLE).

Reset
REQ-024 rst SHALL take priority over start in the same cycle.
REQ-025 On rst: state=IDLE, counters=0, xout=0, xout_valid=0, done=0, busy=0.
REQ-026 rst mid-FILL or mid-DRAIN SHALL abort the block, with no done pulse; storage contents need not be cleared.

Configuration
REQ-027 Macro DEINT_PARALLEL_OUT_EN SHALL control the parallel output.
REQ-028 When the macro is defined, the module SHALL add output blk_out[BS-1:0] and output blk_valid.
REQ-029 With the macro, blk_out bit i = storage index i, registered on the FILL->DRAIN transition; blk_valid pulses one cycle at the same moment.
REQ-030 With the macro, blk_out SHALL hold its value until the next transition, and blk_out and blk_valid SHALL reset to 0.
REQ-031 Without the macro, the ports SHALL be absent and the serial behaviour SHALL be identical.

Verification
REQ-032 Single-one test, defaults: start with stream j=1 high, all other bits 0 -> only DRAIN output index 8 is 1; done on output index 39; first xout_valid 40 cycles after start.
REQ-033 Single-one test: j=5 high -> only output index 1 is 1; j=39 high -> only output index 39 is 1.
REQ-034 Round trip: 40'h1_90_10_21_01 through the matching 5x8 interleaver, then this block -> serial output equals 40'h1_90_10_21_01 bit order; with DEINT_PARALLEL_OUT_EN, blk_out=40'h1_90_10_21_01.
REQ-035 Restart: start at j=0, second start 12 cycles later -> output reflects only the second block; first valid 40 cycles after the second start.
REQ-036 Drain start: start during DRAIN -> ignored, done exactly once.
REQ-037 Reset: rst at DRAIN output index 20 -> next cycle xout_valid=0, busy=0, no done.

Source files
------------

// File: rtl/block_deinterleaver.sv
// Serial ROWS x COLS block de-interleaver: fills row-scattered storage, then drains it in order.
// Optional parallel block output when DEINT_PARALLEL_OUT_EN is defined.
module block_deinterleaver #(
    parameter int ROWS = 5,
    parameter int COLS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic xin,
    output logic xout,
    output logic xout_valid,
    output logic busy,
    output logic done
`ifdef DEINT_PARALLEL_OUT_EN
    ,
    output logic [ROWS*COLS-1:0] blk_out,
    output logic                 blk_valid
`endif
);

    localparam int BS = ROWS * COLS;
    localparam int CW = (BS > 1) ? $clog2(BS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BS - 1);
    localparam logic [CW-1:0] LROW = CW'((ROWS - 1) * COLS);
    localparam logic [CW-1:0] STEP = CW'(COLS);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] widx;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_inc;
    logic [BS-1:0] mem;
    logic [BS-1:0] mem_nxt;
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] widx_nxt;

    assign busy     = (state != IDLE);
    assign rcnt_inc = rcnt + CW'(1);

    // Write address walks down a column; last row wraps to the top of the next column.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = widx;
        if (state == IDLE && start) begin
            wr_en  = 1'b1;
            wr_idx = '0;
        end else if (state == FILL) begin
            wr_en  = 1'b1;
            wr_idx = start ? '0 : widx;
        end
        mem_nxt = mem;
        if (wr_en) mem_nxt[wr_idx] = xin;
        widx_nxt = (wr_idx >= LROW) ? (wr_idx - LROW + CW'(1)) : (wr_idx + STEP);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem <= mem_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            widx       <= '0;
            rcnt       <= '0;
            xout       <= 1'b0;
            xout_valid <= 1'b0;
            done       <= 1'b0;
`ifdef DEINT_PARALLEL_OUT_EN
            blk_out    <= '0;
            blk_valid  <= 1'b0;
`endif
        end else begin
`ifdef DEINT_PARALLEL_OUT_EN
            blk_valid <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        wcnt  <= CW'(1);
                        widx  <= widx_nxt;
                    end
                end
                FILL: begin
                    if (start) begin
                        wcnt <= CW'(1);
                        widx <= widx_nxt;
                    end else if (wcnt == LAST) begin
                        state      <= DRAIN;
                        wcnt       <= '0;
                        widx       <= '0;
                        rcnt       <= '0;
                        xout       <= mem_nxt[0];
                        xout_valid <= 1'b1;
                        done       <= (LAST == '0);
`ifdef DEINT_PARALLEL_OUT_EN
                        blk_out    <= mem_nxt;
                        blk_valid  <= 1'b1;
`endif
                    end else begin
                        wcnt <= wcnt + CW'(1);
                        widx <= widx_nxt;
                    end
                end
                DRAIN: begin
                    if (rcnt == LAST) begin
                        state      <= IDLE;
                        rcnt       <= '0;
                        xout       <= 1'b0;
                        xout_valid <= 1'b0;
                        done       <= 1'b0;
                    end else begin
                        rcnt <= rcnt_inc;
                        xout <= mem[rcnt_inc];
                        done <= (rcnt_inc == LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
